updown_bound_counter: RTL
=========================

# updown_bound_counter

Parametrised up/down counter for the counter library: a WIDTH-bit successor to the fixed 8-bit loadable up/down counter. It adds:
- runtime lower and upper bounds, a programmable step and a count enable;
- a choice of wrap or saturate at the bounds;
- a ping-pong mode with an internal direction state;
- registered overflow and underflow pulses.

It serves as a general event, address or PWM-ramp counter.

## Interface
- WIDTH, 8, counter, bound, step and load width (≥2)
- clk  in  1  rising-edge clock
- clr  in  1  reset; synchronous, active-low
- en  in  1  count enable
- ld  in  1  synchronous load of d_in
- d_in  in  WIDTH  load value
- mode  in  2  00 down, 01 up, 10 ping-pong, 11 hold
- sat  in  1  1 = saturate at bound, 0 = wrap to opposite bound (modes 00/01 only)
- step  in  WIDTH  increment/decrement magnitude, unsigned
- lo  in  WIDTH  lower bound, unsigned
- hi  in  WIDTH  upper bound, unsigned
- count  out  WIDTH  registered count
- dir  out  1  registered direction, 1 = up
- ovf  out  1  registered one-cycle pulse: step attempted to exceed hi
- unf  out  1  registered one-cycle pulse: step attempted to go below lo
- at_hi  out  1  combinational, count == hi
- at_lo  out  1  combinational, count == lo
- err  out  1  combinational, hi < lo

## Operation
Priority at each rising clk edge:
1. **clr=0:** count=0, dir=1, ovf=0, unf=0.
2. **ld=1:** count=d_in, taken unclamped even if outside [lo,hi]. dir and ovf/unf are cleared to 0 except dir, which holds.
3. **en=1 and err=0:** step per mode, below.
4. **Otherwise:** count and dir hold; ovf=unf=0.

Arithmetic:
- Sums use WIDTH+1 bits: up_sum = count + step, so the carry is never lost.
- Down uses a borrow test: below = (count < step) or (count − step < lo).
- Up exceeds when up_sum > hi.

Mode 01 (up):
- dir=1.
- Not exceeding: count = up_sum.
- Exceeding: ovf=1, and count = lo (sat=0) or hi (sat=1).

Mode 00 (down):
- dir=0.
- Not below: count = count − step.
- Below: unf=1, and count = hi (sat=0) or lo (sat=1).

Mode 10 (ping-pong), a two-state direction FSM UP/DN held in dir; sat is ignored:
- UP, not exceeding: count = up_sum; stay UP.
- UP, up_sum ≥ hi: count = hi; go to DN. ovf=1 only if up_sum > hi.
- DN, mirror image: count − step ≤ lo (or borrow) gives count = lo and go to UP. unf=1 only if strictly below lo.
- On entering mode 10, the current dir is used.

Mode 11: count and dir hold; ovf=unf=0.

Boundary rules:
- step=0: count holds; no flags; dir still follows modes 00/01.
- err=1 (hi<lo): enabled steps are suppressed and count holds. clr and ld still act.
- Count outside [lo,hi] (after ld, or after the bounds change): the same rules apply unmodified. Example: up with count > hi always exceeds, so it wraps or clamps with ovf.
- Saturated at a bound and still stepping outward: count stays, and ovf/unf re-asserts every enabled cycle.
- lo == hi: every non-zero step exceeds. count = lo = hi, with a flag each cycle.

## Timing
- All registered outputs update on the rising clk edge following the sampled inputs: one-cycle latency.
- No combinational path from inputs to count, dir, ovf or unf.
- at_hi, at_lo and err are combinational from count/lo/hi, valid in the same cycle.
- ovf/unf are high for exactly the cycle following the offending edge. Consecutive offending edges give a continuous high.
- Reset values: count=0, dir=1, ovf=0, unf=0. at_hi, at_lo and err follow from count=0 and the current lo/hi.
- clr asserted mid-operation overrides ld, en and mode on that edge. Counting resumes on the first edge with clr=1.

## Test plan
All scenarios use WIDTH=8.

1. **Reset override:** count=0x37, dir=0, ld=1, en=1, clr=0 for one edge → count=0x00, dir=1, ovf=unf=0.
2. **Wrap up:** lo=0x10, hi=0x14, step=1, mode=01, sat=0; ld 0x12 then en=1 → count 0x13, 0x14, 0x10; ovf high only in the cycle count=0x10. Also check at_hi=1 at 0x14.
3. **Saturate down:** lo=0x05, step=3, mode=00, sat=1; ld 0x0A → 0x07, 0x05 (unf=1), 0x05 (unf=1). Then mode=11 → count holds at 0x05 and unf=0.
4. **Ping-pong:** lo=0, hi=5, step=2, mode=10, from reset → count 0,2,4,5,3,1,0,2.
   - dir falls on the edge producing 5 and rises on the edge producing 0.
   - ovf pulses on the edge producing 5; unf pulses on the edge producing 0.
5. **Carry and out-of-range load:**
   - lo=0, hi=0xFF, step=0x80, count=0xC0, mode=01, sat=0 → count=0x00, ovf=1 (true sum 0x140).
   - Then hi=0x10, ld d_in=0xFF → count=0xFF, no flag; next up step → count=0x00, ovf=1.
6. **Illegal bounds and zero step:**
   - lo=0x20, hi=0x10 → err=1; en=1 for 3 cycles → count unchanged, no flags.
   - ld 0x33 → count=0x33.
   - Restore hi=0x40, step=0 → count holds at 0x33, no flags.

Source files
------------

// File: rtl/updown_bound_counter.sv
// updown_bound_counter
//
// Parametrised up/down counter with runtime bounds, programmable step,
// wrap-or-saturate behaviour, a ping-pong mode and registered
// overflow/underflow pulses. Usable as an event, address or PWM-ramp counter.
//
// Ports
//   clk    rising-edge clock
//   clr    synchronous active-low reset (highest priority)
//   en     count enable
//   ld     synchronous load of d_in (beats en, loses to clr)
//   d_in   load value, taken unclamped
//   mode   00 down, 01 up, 10 ping-pong, 11 hold
//   sat    1 = saturate at bound, 0 = wrap to opposite bound (modes 00/01)
//   step   unsigned step magnitude
//   lo/hi  unsigned lower/upper bounds
//   count  registered count
//   dir    registered direction (1 = up); doubles as the ping-pong FSM state
//   ovf    registered pulse: a step tried to go above hi
//   unf    registered pulse: a step tried to go below lo
//   at_hi  combinational, count == hi
//   at_lo  combinational, count == lo
//   err    combinational, hi < lo (enabled steps are suppressed)
//
// There is no valid/ready handshake on this block: every input is sampled on
// every rising clk edge and every registered output reflects the previous edge.

module updown_bound_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] d_in,
  input  logic [1:0]       mode,
  input  logic             sat,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             ovf,
  output logic             unf,
  output logic             at_hi,
  output logic             at_lo,
  output logic             err
);

  // Direction register is the ping-pong FSM state; it is visible on dir.
  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

  localparam logic [1:0] MODE_DOWN = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  dir_e             dir_q, dir_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic             ovf_q, ovf_n;
  logic             unf_q, unf_n;

  // Up arithmetic carries one extra bit so count + step never loses its carry.
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   hi_ext;
  logic             up_over;   // up_sum >  hi
  logic             up_reach;  // up_sum >= hi

  // Down arithmetic: a borrow (count < step) always counts as below lo,
  // because the wrapped difference would otherwise look like a large value.
  logic             borrow;
  logic [WIDTH-1:0] dn_diff;
  logic             dn_under;  // true result <  lo
  logic             dn_reach;  // true result <= lo

  assign up_sum   = {1'b0, count_q} + {1'b0, step};
  assign hi_ext   = {1'b0, hi};
  assign up_over  = (up_sum > hi_ext);
  assign up_reach = (up_sum >= hi_ext);

  assign borrow   = (count_q < step);
  assign dn_diff  = count_q - step;
  assign dn_under = borrow || (dn_diff < lo);
  assign dn_reach = borrow || (dn_diff <= lo);

  assign err   = (hi < lo);
  assign at_hi = (count_q == hi);
  assign at_lo = (count_q == lo);

  // Next-state logic. clr is handled in the register block; everything else
  // (load, enabled step, hold) is decided here. Flags default to 0 so they
  // only pulse on cycles that actually offend.
  always_comb begin
    count_n = count_q;
    dir_n   = dir_q;
    ovf_n   = 1'b0;
    unf_n   = 1'b0;

    if (ld) begin
      count_n = d_in;
    end else if (en && !err) begin
      if (step == '0) begin
        // Zero step never moves the count or raises a flag; the fixed
        // direction modes still report their direction.
        if (mode == MODE_DOWN) dir_n = DIR_DN;
        else if (mode == MODE_UP) dir_n = DIR_UP;
      end else begin
        case (mode)
          MODE_UP: begin
            dir_n = DIR_UP;
            if (up_over) begin
              ovf_n   = 1'b1;
              count_n = sat ? hi : lo;
            end else begin
              count_n = up_sum[WIDTH-1:0];
            end
          end
          MODE_DOWN: begin
            dir_n = DIR_DN;
            if (dn_under) begin
              unf_n   = 1'b1;
              count_n = sat ? lo : hi;
            end else begin
              count_n = dn_diff;
            end
          end
          MODE_PP: begin
            // Reaching a bound exactly turns around without a flag;
            // overshooting it turns around and flags.
            if (dir_q == DIR_UP) begin
              if (up_reach) begin
                count_n = hi;
                dir_n   = DIR_DN;
                ovf_n   = up_over;
              end else begin
                count_n = up_sum[WIDTH-1:0];
              end
            end else begin
              if (dn_reach) begin
                count_n = lo;
                dir_n   = DIR_UP;
                unf_n   = dn_under;
              end else begin
                count_n = dn_diff;
              end
            end
          end
          MODE_HOLD: begin
            count_n = count_q;
          end
          default: begin
            count_n = count_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      count_q <= '0;
      dir_q   <= DIR_UP;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_n;
      dir_q   <= dir_n;
      ovf_q   <= ovf_n;
      unf_q   <= unf_n;
    end
  end

  assign count = count_q;
  assign dir   = (dir_q == DIR_UP);
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule
